// File: rtl/regfile_scan_checker_if.sv
// Register-file read port and word-stream handshake shared by the scan
// checker (master) and the register file plus consumer side (slave).
interface regfile_scan_checker_if #(
  parameter int AW = 5,
  parameter int DW = 32
) ();
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_idx;
  logic          out_err;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output rd_addr, out_data, out_idx, out_err, out_valid,
    input  rd_data, out_ready
  );

  modport slave (
    input  rd_addr, out_data, out_idx, out_err, out_valid,
    output rd_data, out_ready
  );
endinterface

// File: rtl/regfile_scan_checker.sv
// Walks the register file after a Fibonacci fill, compares each word with an
// internally generated expected value and streams it out on valid/ready,
// keeping a saturating mismatch count and the first failing index.
module regfile_scan_checker #(
  parameter int NUM_REGS = 32,
  parameter int AW       = 5,
  parameter int DW       = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  regfile_scan_checker_if.master bus,
  output logic                   busy,
  output logic                   done,
  output logic [5:0]             err_cnt,
  output logic [AW-1:0]          first_err_idx
);

  typedef enum logic [2:0] {IDLE, WAIT, SAMPLE, SEND, DONE} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] idx;
  logic [DW-1:0] exp_a;
  logic [DW-1:0] exp_b;
  logic          launch;
  logic          accept;
  logic          last_idx;
  logic          mismatch;

  // A start is only honoured between scans; a word leaves on ready in SEND.
  assign launch   = start && (state == IDLE || state == DONE);
  assign accept   = (state == SEND) && bus.out_ready;
  assign last_idx = (idx == AW'(NUM_REGS - 1));
  assign mismatch = (bus.rd_data != exp_a);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: one settle cycle, one sample cycle, then wait for the consumer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = WAIT;
      WAIT:       state_nxt = SAMPLE;
      SAMPLE:     state_nxt = SEND;
      SEND:       if (bus.out_ready) state_nxt = last_idx ? DONE : WAIT;
      default:    state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy = (state == WAIT) || (state == SAMPLE) || (state == SEND);
    done = (state == DONE);
  end

  // Datapath: address walk, expected-value generator, output word and error tally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx           <= '0;
      exp_a         <= DW'(1);
      exp_b         <= DW'(1);
      bus.rd_addr   <= '0;
      bus.out_data  <= '0;
      bus.out_idx   <= '0;
      bus.out_err   <= 1'b0;
      bus.out_valid <= 1'b0;
      err_cnt       <= '0;
      first_err_idx <= '0;
    end else begin
      if (launch) begin
        idx           <= '0;
        bus.rd_addr   <= '0;
        exp_a         <= DW'(1);
        exp_b         <= DW'(1);
        err_cnt       <= '0;
        first_err_idx <= '0;
      end
      if (state == SAMPLE) begin
        bus.out_data  <= bus.rd_data;
        bus.out_idx   <= idx;
        bus.out_err   <= mismatch;
        bus.out_valid <= 1'b1;
        if (mismatch) begin
          if (err_cnt != 6'd63) err_cnt <= err_cnt + 6'd1;
          if (err_cnt == 6'd0)  first_err_idx <= idx;
        end
      end
      if (accept) begin
        bus.out_valid <= 1'b0;
        if (!last_idx) begin
          idx         <= idx + 1'b1;
          bus.rd_addr <= idx + 1'b1;
          exp_a       <= exp_b;
          exp_b       <= exp_a + exp_b;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_scan_checker.sv
// Self-checking bench for regfile_scan_checker: a register-file array feeds the
// read port, a Fibonacci table is the reference, and a negedge monitor checks
// every streamed word, the error tally and the scan completion.
module tb_regfile_scan_checker;
  localparam int NUM_REGS = 32;
  localparam int AW       = 5;
  localparam int DW       = 32;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic          done;
  logic [5:0]    err_cnt;
  logic [AW-1:0] first_err_idx;

  regfile_scan_checker_if #(.AW(AW), .DW(DW)) ifc ();

  regfile_scan_checker #(.NUM_REGS(NUM_REGS), .AW(AW), .DW(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .bus           (ifc),
    .busy          (busy),
    .done          (done),
    .err_cnt       (err_cnt),
    .first_err_idx (first_err_idx)
  );

  logic [DW-1:0] regs [NUM_REGS];
  logic [DW-1:0] fib  [NUM_REGS];

  assign ifc.rd_data = regs[ifc.rd_addr];

  int tests = 0;
  int fails = 0;

  // Scan-level reference state kept by the monitor.
  bit            active = 0;
  int            mon_idx = 0;
  int            mon_err = 0;
  int            mon_first = 0;
  int            words = 0;
  int            cyc = 0;
  int            done_cyc = -1;
  logic          prev_valid = 0;
  logic          prev_ready = 0;
  logic          prev_done = 0;
  logic [DW-1:0] prev_data = '0;
  logic [AW-1:0] prev_idx = '0;
  logic          prev_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_rd_addr"},   ifc.rd_addr, 0);
    checkOutput({tag, "_out_data"},  ifc.out_data, 0);
    checkOutput({tag, "_out_idx"},   ifc.out_idx, 0);
    checkOutput({tag, "_out_err"},   ifc.out_err, 0);
    checkOutput({tag, "_out_valid"}, ifc.out_valid, 0);
    checkOutput({tag, "_busy"},      busy, 0);
    checkOutput({tag, "_done"},      done, 0);
    checkOutput({tag, "_err_cnt"},   err_cnt, 0);
    checkOutput({tag, "_first_err"}, first_err_idx, 0);
  endtask

  // One-cycle start pulse, entered and left at posedge+1.
  task automatic applyStimulus(input bit check_clear);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
    if (check_clear) begin
      checkOutput("done_cleared", done, 0);
      checkOutput("err_cnt_cleared", err_cnt, 0);
    end
  endtask

  task automatic waitDone(input int budget, input bit rand_ready);
    bit got;
    got = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done) begin
        got = 1;
        break;
      end
      if (rand_ready) ifc.out_ready = ($urandom_range(0, 3) != 0);
    end
    checkOutput("done_within_budget", got, 1);
    ifc.out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic waitWord(input int want);
    bit got;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      if (ifc.out_valid && ifc.out_idx == AW'(want)) begin
        got = 1;
        break;
      end
      @(posedge clk); #1;
    end
    checkOutput("word_seen", got, 1);
  endtask

  // Compare process: checks every streamed word and each scan completion.
  always @(negedge clk) begin
    if (!rst_n) begin
      active     = 0;
      prev_valid = 0;
      prev_ready = 0;
      prev_done  = 0;
    end else begin
      cyc++;
      if (start && !busy) begin
        active    = 1;
        mon_idx   = 0;
        mon_err   = 0;
        mon_first = 0;
        words     = 0;
        cyc       = -1;
        done_cyc  = -1;
      end
      if (prev_valid && prev_ready) begin
        checkOutput("valid_drops_after_accept", ifc.out_valid, 0);
      end else if (prev_valid) begin
        checkOutput("stall_valid_held", ifc.out_valid, 1);
        checkOutput("stall_data_held", ifc.out_data, prev_data);
        checkOutput("stall_idx_held", ifc.out_idx, prev_idx);
        checkOutput("stall_err_held", ifc.out_err, prev_err);
      end else if (ifc.out_valid) begin
        checkOutput("word_while_active", active, 1);
        if (active && mon_idx < NUM_REGS) begin
          checkOutput("word_idx", ifc.out_idx, mon_idx);
          checkOutput("word_data", ifc.out_data, regs[mon_idx]);
          checkOutput("word_err", ifc.out_err, regs[mon_idx] != fib[mon_idx]);
          if (regs[mon_idx] != fib[mon_idx]) begin
            if (mon_err == 0) mon_first = mon_idx;
            if (mon_err < 63) mon_err++;
          end
          checkOutput("err_cnt_running", err_cnt, mon_err);
          if (mon_err != 0) checkOutput("first_err_running", first_err_idx, mon_first);
        end else if (active) begin
          checkOutput("idx_overrun", mon_idx, NUM_REGS - 1);
        end
      end
      if (ifc.out_valid && ifc.out_ready && !prev_valid) begin
        mon_idx++;
        words++;
      end else if (ifc.out_valid && ifc.out_ready && prev_valid && !prev_ready) begin
        mon_idx++;
        words++;
      end
      if (done && !prev_done) begin
        checkOutput("done_while_active", active, 1);
        checkOutput("scan_word_count", words, NUM_REGS);
        checkOutput("scan_err_cnt", err_cnt, mon_err);
        if (mon_err != 0) checkOutput("scan_first_err", first_err_idx, mon_first);
        checkOutput("busy_low_at_done", busy, 0);
        done_cyc = cyc;
        active   = 0;
      end
      prev_valid = ifc.out_valid;
      prev_ready = ifc.out_ready;
      prev_done  = done;
      prev_data  = ifc.out_data;
      prev_idx   = ifc.out_idx;
      prev_err   = ifc.out_err;
    end
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    ifc.out_ready = 1'b1;
    fib[0] = 1;
    fib[1] = 1;
    for (int i = 2; i < NUM_REGS; i++) fib[i] = fib[i-1] + fib[i-2];
    for (int i = 0; i < NUM_REGS; i++) regs[i] = fib[i];

    checkOutput("model_fib5", fib[5], 8);
    checkOutput("model_fib20", fib[20], 10946);
    checkOutput("model_fib31", fib[31], 2178309);

    #12;
    checkResetOutputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("idle");

    // Clean scan with ready held high.
    applyStimulus(0);
    waitDone(200, 0);
    checkOutput("clean_done_cycle", done_cyc, 96);
    checkOutput("clean_err_cnt", err_cnt, 0);

    // Two corrupted words; restart from DONE also checks the clear.
    regs[5]  = 7;
    regs[20] = 0;
    applyStimulus(1);
    waitDone(200, 0);
    checkOutput("corrupt_err_cnt", err_cnt, 2);
    checkOutput("corrupt_first_err", first_err_idx, 5);
    checkOutput("corrupt_done_cycle", done_cyc, 96);

    // Repeat the identical scan.
    applyStimulus(1);
    waitDone(200, 0);
    checkOutput("repeat_err_cnt", err_cnt, 2);
    checkOutput("repeat_first_err", first_err_idx, 5);
    checkOutput("repeat_done_cycle", done_cyc, 96);

    // Consumer stalls for 10 cycles on word 3.
    for (int i = 0; i < NUM_REGS; i++) regs[i] = fib[i];
    applyStimulus(1);
    waitWord(3);
    ifc.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checkOutput("stall_rd_addr", ifc.rd_addr, 3);
      checkOutput("stall_out_valid", ifc.out_valid, 1);
      checkOutput("stall_out_data", ifc.out_data, 3);
      checkOutput("stall_out_idx", ifc.out_idx, 3);
    end
    ifc.out_ready = 1'b1;
    waitDone(200, 0);
    checkOutput("stall_err_cnt", err_cnt, 0);

    // Start while busy is ignored and does not clear the tally.
    regs[2] = 99;
    applyStimulus(1);
    waitWord(10);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("busy_start_keeps_err", err_cnt, 1);
    checkOutput("busy_start_still_busy", busy, 1);
    waitDone(200, 0);
    checkOutput("busy_start_err_cnt", err_cnt, 1);
    checkOutput("busy_start_first_err", first_err_idx, 2);
    checkOutput("busy_start_done_cycle", done_cyc, 96);

    // Asynchronous reset while word 15 is waiting in SEND.
    regs[2] = fib[2];
    applyStimulus(1);
    waitWord(15);
    ifc.out_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midscan_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    ifc.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checkResetOutputs("post_reset_idle");
    applyStimulus(0);
    waitDone(200, 0);
    checkOutput("post_reset_done_cycle", done_cyc, 96);
    checkOutput("post_reset_err_cnt", err_cnt, 0);

    // Randomised corruption and consumer backpressure.
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] = ($urandom_range(0, 5) == 0) ? DW'($urandom) : fib[i];
      applyStimulus(1);
      waitDone(2000, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
